// File: rtl/clock_div_gen.sv
// clock_div_gen: NUM_CH independent programmable clock dividers driven from one
// fabric clock. Each channel produces a registered divided-clock level and a
// one-cycle tick at the start of every period. Period and high time can be
// reprogrammed at runtime; running channels stage the new values in a shadow
// register and switch over on a period boundary, so outputs never glitch.
//
// Config handshake: a write transfers on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is combinational from cfg_chan and the
// pending bits; it drops only while the addressed channel still holds an
// unapplied shadow. Writes to channel numbers >= NUM_CH transfer and are dropped.
module clock_div_gen #(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int RST_PERIOD = 2,
  parameter int RST_HIGH   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]  cfg_period,
  input  logic [DIV_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] P_RESET = DIV_W'(RST_PERIOD);
  localparam logic [DIV_W-1:0] H_RESET = DIV_W'(RST_HIGH);

  // Per-channel FSM state; kept as a named array so checkers can bind to it.
  ch_state_e        state_q      [NUM_CH];
  ch_state_e        state_d      [NUM_CH];

  logic [DIV_W-1:0] cnt_q        [NUM_CH];
  logic [DIV_W-1:0] cnt_d        [NUM_CH];
  logic [DIV_W-1:0] act_period_q [NUM_CH];
  logic [DIV_W-1:0] act_period_d [NUM_CH];
  logic [DIV_W-1:0] act_high_q   [NUM_CH];
  logic [DIV_W-1:0] act_high_d   [NUM_CH];
  logic [DIV_W-1:0] shd_period_q [NUM_CH];
  logic [DIV_W-1:0] shd_period_d [NUM_CH];
  logic [DIV_W-1:0] shd_high_q   [NUM_CH];
  logic [DIV_W-1:0] shd_high_d   [NUM_CH];

  logic [NUM_CH-1:0] clk_q,  clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic              rdy_en_q, rdy_en_d;

  logic              sel_pend;
  logic              wr_acc;
  logic [NUM_CH-1:0] wr_hit;

  // Config handshake: ready unless the addressed channel already has a shadow waiting.
  always_comb begin
    sel_pend = 1'b0;
    wr_hit   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_chan == CH_W'(i)) begin
        sel_pend = pend_q[i];
      end
    end
    cfg_ready = rdy_en_q & ~sel_pend;
    wr_acc    = cfg_valid & cfg_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_acc && (cfg_chan == CH_W'(i));
    end
    rdy_en_d = 1'b1;
  end

  // Next state: a channel runs whenever it is enabled and its effective period is non-zero.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = (en[i] && (act_period_d[i] != '0)) ? ST_RUN : ST_IDLE;
    end
  end

  // Counter, config staging and registered outputs for each channel.
  always_comb begin
    logic             wrap;
    logic [DIV_W-1:0] cnt_inc;
    wrap    = 1'b0;
    cnt_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      act_period_d[i] = act_period_q[i];
      act_high_d[i]   = act_high_q[i];
      shd_period_d[i] = shd_period_q[i];
      shd_high_d[i]   = shd_high_q[i];
      pend_d[i]       = pend_q[i];
      cnt_d[i]        = '0;
      tick_d[i]       = 1'b0;
      clk_d[i]        = 1'b0;
      cnt_inc         = cnt_q[i] + ONE;
      if (state_q[i] == ST_RUN && en[i]) begin
        // A RUN channel that shows cnt=0 without a tick has only just entered RUN,
        // so its first period starts now. sync and the natural wrap share one tick.
        wrap = sync ||
               ((cnt_q[i] == '0) && !tick_q[i]) ||
               (cnt_q[i] >= act_period_q[i] - ONE);
        if (wrap) begin
          if (pend_q[i]) begin
            act_period_d[i] = shd_period_q[i];
            act_high_d[i]   = shd_high_q[i];
            pend_d[i]       = 1'b0;
          end
          if (wr_hit[i]) begin
            shd_period_d[i] = cfg_period;
            shd_high_d[i]   = cfg_high;
            pend_d[i]       = 1'b1;
          end
          if (act_period_d[i] != '0) begin
            tick_d[i] = 1'b1;
            clk_d[i]  = (act_high_d[i] != '0);
          end
        end else begin
          cnt_d[i] = cnt_inc;
          clk_d[i] = (cnt_inc < act_high_q[i]);
          if (wr_hit[i]) begin
            shd_period_d[i] = cfg_period;
            shd_high_d[i]   = cfg_high;
            pend_d[i]       = 1'b1;
          end
        end
      end else begin
        // Idle (or leaving RUN): flush any staged shadow, then take writes directly.
        if (pend_q[i]) begin
          act_period_d[i] = shd_period_q[i];
          act_high_d[i]   = shd_high_q[i];
        end
        pend_d[i] = 1'b0;
        if (wr_hit[i]) begin
          act_period_d[i] = cfg_period;
          act_high_d[i]   = cfg_high;
        end
      end
    end
  end

  // State and datapath registers; reset drops all staged configs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]      <= ST_IDLE;
        cnt_q[i]        <= '0;
        act_period_q[i] <= P_RESET;
        act_high_q[i]   <= H_RESET;
        shd_period_q[i] <= '0;
        shd_high_q[i]   <= '0;
      end
      clk_q    <= '0;
      tick_q   <= '0;
      pend_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]      <= state_d[i];
        cnt_q[i]        <= cnt_d[i];
        act_period_q[i] <= act_period_d[i];
        act_high_q[i]   <= act_high_d[i];
        shd_period_q[i] <= shd_period_d[i];
        shd_high_q[i]   <= shd_high_d[i];
      end
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  assign div_clk     = clk_q;
  assign div_tick    = tick_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_clock_div_gen.sv
// Directed testbench for clock_div_gen (NUM_CH=4, DIV_W=16, reset period 2 / high 1).
module tb_clock_div_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan;
  logic [DIV_W-1:0]  cfg_period;
  logic [DIV_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] div_tick;
  logic [NUM_CH-1:0] cfg_pending;

  int n_assert = 0;
  int n_fail   = 0;

  clock_div_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W), .RST_PERIOD(2), .RST_HIGH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .div_clk(div_clk), .div_tick(div_tick), .cfg_pending(cfg_pending)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_set(input logic [CH_W-1:0] ch, input int p, input int h);
    cfg_valid  = 1'b1;
    cfg_chan   = ch;
    cfg_period = DIV_W'(p);
    cfg_high   = DIV_W'(h);
  endtask

  // Watchdog in case the sequence below stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = '0; sync = 1'b0;
    cfg_valid = 1'b0; cfg_chan = '0; cfg_period = '0; cfg_high = '0;

    // Reset defaults
    step(); step();
    chk("rst_div_clk", div_clk, 4'b0000);
    chk("rst_div_tick", div_tick, 4'b0000);
    chk("rst_pending", cfg_pending, 4'b0000);
    chk("rst_ready", cfg_ready, 1'b0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", cfg_ready, 1'b0);
    step();
    chk("ready_after_edge", cfg_ready, 1'b1);

    // ch0 with reset config: period 2, high 1
    en = 4'b0001;
    step();
    chk("ch0_enter_clk", div_clk, 4'b0000);
    chk("ch0_enter_tick", div_tick, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("ch0_clk_%0d", k), div_clk, (k % 2 == 0) ? 4'b0001 : 4'b0000);
      chk($sformatf("ch0_tick_%0d", k), div_tick, (k % 2 == 0) ? 4'b0001 : 4'b0000);
    end

    // ch1 programmed while idle: period 5, high 2
    cfg_set(2'd1, 5, 2);
    #1 chk("ch1_idle_ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    chk("ch1_idle_no_pending", cfg_pending, 4'b0000);
    en = 4'b0011;
    step();
    chk("ch1_enter_clk", div_clk[1], 1'b0);
    chk("ch1_enter_tick", div_tick[1], 1'b0);
    for (int k = 0; k < 11; k++) begin
      step();
      chk($sformatf("ch1_p5_clk_%0d", k), div_clk[1], (k % 5 < 2) ? 1'b1 : 1'b0);
      chk($sformatf("ch1_p5_tick_%0d", k), div_tick[1], (k % 5 == 0) ? 1'b1 : 1'b0);
    end

    // Mid-run reconfigure of ch1 at cnt=2 to period 3, high 1
    step(); step();
    chk("ch1_cnt2_clk", div_clk[1], 1'b0);
    cfg_set(2'd1, 3, 1);
    #1 chk("ch1_run_ready", cfg_ready, 1'b1);
    step();
    // Second write to ch1 while its shadow is pending must stall
    cfg_set(2'd1, 7, 7);
    #1 chk("ch1_pending_set", cfg_pending, 4'b0010);
    chk("ch1_stall_ready", cfg_ready, 1'b0);
    step();
    chk("ch1_still_pending", cfg_pending, 4'b0010);
    chk("ch1_still_stalled", cfg_ready, 1'b0);
    chk("ch1_cnt4_clk", div_clk[1], 1'b0);
    // ch2 is writable in the same window
    cfg_set(2'd2, 6, 3);
    #1 chk("ch2_ready_in_window", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    chk("ch1_wrap_tick", div_tick[1], 1'b1);
    chk("ch1_wrap_clk", div_clk[1], 1'b1);
    chk("ch1_pending_clear", cfg_pending, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("ch1_p3_clk_%0d", k), div_clk[1], (k % 3 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("ch1_p3_tick_%0d", k), div_tick[1], (k % 3 == 0) ? 1'b1 : 1'b0);
    end

    // Sync: ch0 period 4 high 2, ch2 period 6 high 3
    en = 4'b0000;
    step();
    chk("all_idle_clk", div_clk, 4'b0000);
    chk("all_idle_tick", div_tick, 4'b0000);
    cfg_set(2'd0, 4, 2);
    step();
    cfg_valid = 1'b0;
    chk("ch0_idle_write", cfg_pending, 4'b0000);
    en = 4'b0101;
    step();
    chk("s_enter_tick", div_tick, 4'b0000);
    step();
    chk("s_c0_tick", div_tick, 4'b0101);
    chk("s_c0_clk", div_clk, 4'b0101);
    step();
    chk("s_c1_tick", div_tick, 4'b0000);
    chk("s_c1_clk", div_clk, 4'b0101);
    step();
    chk("s_c2_clk", div_clk, 4'b0100);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync1_tick", div_tick, 4'b0101);
    chk("sync1_clk", div_clk, 4'b0101);
    // Stage period 2 high 1 on ch2; sync should apply it
    cfg_set(2'd2, 2, 1);
    step();
    cfg_valid = 1'b0;
    chk("ch2_shadow_pending", cfg_pending, 4'b0100);
    chk("s_d1_clk", div_clk, 4'b0101);
    step();
    chk("s_d2_clk", div_clk, 4'b0100);
    step();
    chk("s_d3_clk", div_clk, 4'b0000);
    chk("s_d3_tick", div_tick, 4'b0000);
    // ch0 is at period-1 here: sync coincides with its natural wrap
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync2_tick", div_tick, 4'b0101);
    chk("sync2_clk", div_clk, 4'b0101);
    chk("sync2_pending", cfg_pending, 4'b0000);
    step();
    chk("sync2_single_tick", div_tick, 4'b0000);
    chk("sync2_next_clk", div_clk, 4'b0001);
    step();
    chk("ch2_p2_tick", div_tick, 4'b0100);
    chk("ch2_p2_clk", div_clk, 4'b0100);

    // period 0 keeps ch3 idle despite en
    en = 4'b0000;
    step();
    cfg_set(2'd3, 0, 0);
    step();
    cfg_valid = 1'b0;
    en = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("p0_clk_%0d", k), div_clk, 4'b0000);
      chk($sformatf("p0_tick_%0d", k), div_tick, 4'b0000);
    end

    // period 1, high 1: clock stuck high, tick every cycle
    cfg_set(2'd3, 1, 1);
    step();
    cfg_valid = 1'b0;
    chk("p1_enter_clk", div_clk, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("p1_tick_%0d", k), div_tick, 4'b1000);
      chk($sformatf("p1_clk_%0d", k), div_clk, 4'b1000);
    end

    // Reset mid-run discards the pending shadow
    cfg_set(2'd3, 5, 2);
    #1 chk("pre_rst_ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    chk("pre_rst_pending", cfg_pending, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", div_clk, 4'b0000);
    chk("mid_rst_tick", div_tick, 4'b0000);
    chk("mid_rst_pending", cfg_pending, 4'b0000);
    chk("mid_rst_ready", cfg_ready, 1'b0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_ready", cfg_ready, 1'b1);
    chk("post_rst_clk", div_clk, 4'b0000);
    step();
    chk("post_rst_tick0", div_tick, 4'b1000);
    chk("post_rst_clk0", div_clk, 4'b1000);
    step();
    chk("post_rst_tick1", div_tick, 4'b0000);
    chk("post_rst_clk1", div_clk, 4'b0000);
    step();
    chk("post_rst_tick2", div_tick, 4'b1000);

    // en falling with a pending shadow applies it on entry to idle
    cfg_set(2'd3, 4, 4);
    step();
    cfg_valid = 1'b0;
    chk("fall_pending_set", cfg_pending, 4'b1000);
    en = 4'b0000;
    step();
    chk("fall_pending_clear", cfg_pending, 4'b0000);
    chk("fall_clk", div_clk, 4'b0000);
    chk("fall_tick", div_tick, 4'b0000);
    en = 4'b1000;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("hi_ge_p_clk_%0d", k), div_clk, 4'b1000);
      chk($sformatf("hi_ge_p_tick_%0d", k), div_tick, (k % 4 == 0) ? 4'b1000 : 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_div_gen.md
Name: clock_div_gen

Overview:
- Synthesisable, parametrised successor to the simulation-only clock generator.
- Derives NUM_CH independent divided clocks and one-cycle tick enables from a single fabric clock.
- Each channel has a runtime-programmable period and high time, a per-channel enable, and a global phase-alignment sync.
- Used by datapath and testbench infrastructure wherever slower strobes or divided clocks are needed without extra MMCMs.

Parameters:
- NUM_CH, 4, number of independent output channels (1..32).
- DIV_W, 16, width of the period and high-time counters.
- CH_W, $clog2(NUM_CH) with a minimum of 1, width of the channel index.
- RST_PERIOD, 2, period loaded into every channel at reset.
- RST_HIGH, 1, high time loaded into every channel at reset.

Ports:
- clk  input  1  fabric clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  NUM_CH  per-channel run enable, level-sensitive.
- sync  input  1  single-cycle pulse that realigns the phase of all running channels.
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  configuration write accepted this cycle when high together with cfg_valid.
- cfg_chan  input  CH_W  target channel of the write.
- cfg_period  input  DIV_W  new period in clk cycles.
- cfg_high  input  DIV_W  new high time in clk cycles.
- div_clk  output  NUM_CH  registered divided-clock level per channel.
- div_tick  output  NUM_CH  one-cycle pulse marking the start of each period.
- cfg_pending  output  NUM_CH  high while a shadow configuration waits to be applied.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters = 0; div_clk = 0; div_tick = 0; cfg_pending = 0; cfg_ready = 0.
  - Active registers are loaded with period = RST_PERIOD and high = RST_HIGH.
- After reset release: cfg_ready = 1 from the first clk edge onward.
- Per channel, two states: IDLE (en = 0) and RUN (en = 1).
- IDLE:
  - Counter is held at 0; div_clk = 0; div_tick = 0.
  - An accepted config goes straight into the active registers, and pending stays 0.
- IDLE to RUN (en sampled high at edge t):
  - At edge t+1: cnt = 0, div_tick = 1, div_clk = (high != 0).
  - Counter then increments each cycle.
  - When cnt = period-1, the next cycle has cnt = 0 and div_tick = 1 (wrap).
- RUN to IDLE (en sampled low): outputs and counter return to 0 on the next edge, with no partial-period completion.
- Level rule: div_clk = (cnt < high), registered so that it aligns with cnt.
- Edge cases:
  - high >= period: div_clk is constantly 1.
  - high = 0: div_clk is constantly 0, but ticks still occur.
  - period = 0: channel behaves as IDLE even when en = 1.
  - period = 1: div_tick = 1 every cycle, and div_clk = (high != 0).
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - cfg_ready = 0 when the addressed channel already has cfg_pending = 1; otherwise cfg_ready = 1.
  - cfg_ready is combinational from cfg_chan and the pending bits.
  - cfg_chan >= NUM_CH: the write is accepted and discarded.
- Glitch-free update for a RUN channel:
  - The write goes to a shadow register and sets cfg_pending.
  - The shadow copies to active on the cycle the counter wraps to 0 (the same cycle as div_tick); pending clears on that edge.
  - The new period governs that new period in full.
- sync:
  - Every channel in RUN gets cnt = 0 and div_tick = 1 on the next edge; all pending shadows are applied on that edge.
  - IDLE channels are unaffected.
  - sync coinciding with a natural wrap produces a single tick, not two.
- Simultaneous cases:
  - cfg write to a channel that is wrapping this cycle: the new value goes to the shadow and is applied at the following wrap.
  - en falling with pending = 1: the shadow is applied immediately on entry to IDLE.
- Reset mid-operation discards all pending configs.
- Latency: en and sync to first tick is 1 cycle. Config applies at the next wrap (RUN) or in 1 cycle (IDLE).

Test Plan:
- Reset defaults: release reset, en = 4'b0001 → ch0 div_clk toggles 1,0,1,0; div_tick every 2 cycles; other channels stay 0.
- Program ch1 with period = 5, high = 2 while IDLE, then en[1] = 1 → div_clk 1,1,0,0,0 repeating; div_tick at cycles 0,5,10.
- Reconfigure ch1 mid-run to period = 3, high = 1 at cnt = 2 → cfg_pending = 1 until the wrap; old 5-cycle period completes, then 1,0,0 repeats; no glitch.
- Second write to ch1 while pending → cfg_ready = 0 until the wrap; a write to ch2 in the same window is accepted.
- ch0 period = 4, ch2 period = 6 both running; pulse sync → both div_tick = 1 on the next edge and cnt = 0; sync on a natural wrap yields one tick.
- Edge values: period = 0 with en = 1 → all outputs 0; period = 1, high = 1 → div_clk stuck at 1, tick every cycle; assert rst_n low mid-run → outputs 0 immediately, pending cleared.
